// File: rtl/sram_bist_if.sv
// SRAM access bus between the BIST sequencer (master) and the SRAM interface block (slave).
interface sram_bist_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  o_m_write;
  logic [ADDR_WIDTH-1:0] o_m_addr;
  logic [DATA_WIDTH-1:0] o_m_wdata;
  logic [DATA_WIDTH-1:0] i_m_rdata;

  modport master (output o_m_write, output o_m_addr, output o_m_wdata, input  i_m_rdata);
  modport slave  (input  o_m_write, input  o_m_addr, input  o_m_wdata, output i_m_rdata);
endinterface

// File: rtl/sram_bist.sv
// Four-pass write/verify SRAM self-test: WR E, RD E, WR ~E, RD ~E over 0..LAST_ADDR,
// reporting pass/fail, a saturating error count and the first failing address/data.
module sram_bist #(
  parameter int          ADDR_WIDTH    = 20,
  parameter int          DATA_WIDTH    = 8,
  parameter int unsigned LAST_ADDR     = (2 ** ADDR_WIDTH) - 1,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          ERR_WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  sram_bist_if.master           m_if,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ERR_WIDTH-1:0]  o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [DATA_WIDTH-1:0] o_first_err_data
);

  localparam int                  CYC_W     = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CYC_W-1:0]    CYC_LAST  = CYC_W'(ACCESS_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WR_INV, S_RD_INV, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CYC_W-1:0]      r_cyc;
  logic [15:0]           r_lfsr;
  logic [ERR_WIDTH-1:0]  r_err;
  logic [ADDR_WIDTH-1:0] r_ferr_addr;
  logic [DATA_WIDTH-1:0] r_ferr_data;

  logic                  w_busy, w_start, w_step, w_pass_end, w_inv, w_rd, w_wr, w_mis;
  logic [15:0]           w_lfsr_nxt;
  logic [31:0]           w_bit_idx;
  logic [DATA_WIDTH-1:0] w_pat, w_exp;

  assign w_busy     = (r_state == S_WR) || (r_state == S_RD) ||
                      (r_state == S_WR_INV) || (r_state == S_RD_INV);
  assign w_start    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_step     = w_busy && (r_cyc == CYC_LAST);   // last clock of the current access
  assign w_pass_end = w_step && (r_addr == ADDR_LAST);
  assign w_inv      = (r_state == S_WR_INV) || (r_state == S_RD_INV);
  assign w_rd       = (r_state == S_RD) || (r_state == S_RD_INV);
  assign w_wr       = (r_state == S_WR) || (r_state == S_WR_INV);
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_bit_idx  = 32'(r_addr) % 32'(DATA_WIDTH);

  // Pattern generator: E(addr) for the latched mode, inverted during the *_INV passes
  always_comb begin
    w_pat = '0;
    case (r_mode)
      2'd0:    w_pat = DATA_WIDTH'(r_addr);
      2'd1:    w_pat = r_lfsr[DATA_WIDTH-1:0];
      2'd2:    w_pat = DATA_WIDTH'(1) << w_bit_idx;
      default: for (int i = 0; i < DATA_WIDTH; i++) w_pat[i] = ((i % 2) == 0) ^ r_addr[0];
    endcase
    w_exp = w_inv ? ~w_pat : w_pat;
  end

  assign w_mis = w_rd && w_step && (m_if.i_m_rdata != w_exp);

  // State register
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state: each pass advances after its access to LAST_ADDR completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start)    w_state_nxt = S_WR;
      S_WR:           if (w_pass_end) w_state_nxt = S_RD;
      S_RD:           if (w_pass_end) w_state_nxt = S_WR_INV;
      S_WR_INV:       if (w_pass_end) w_state_nxt = S_RD_INV;
      S_RD_INV:       if (w_pass_end) w_state_nxt = S_DONE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // Address/LFSR sequencing and error capture; wrap and reseed between passes
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_mode      <= '0;
      r_addr      <= '0;
      r_cyc       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_err       <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
    end else if (w_start) begin
      r_mode      <= i_mode;
      r_addr      <= '0;
      r_cyc       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_err       <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
    end else if (w_busy) begin
      if (w_step) begin
        r_cyc <= '0;
        if (w_pass_end) begin
          r_addr <= '0;
          r_lfsr <= LFSR_SEED;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_lfsr <= w_lfsr_nxt;
        end
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_mis) begin
        if (r_err != '1) r_err <= r_err + 1'b1;
        // counter saturates and never returns to zero, so zero means "no error yet"
        if (r_err == '0) begin
          r_ferr_addr <= r_addr;
          r_ferr_data <= m_if.i_m_rdata;
        end
      end
    end
  end

  assign m_if.o_m_write = w_wr;
  assign m_if.o_m_addr  = r_addr;
  assign m_if.o_m_wdata = w_busy ? w_exp : '0;

  assign o_busy           = w_busy;
  assign o_done           = (r_state == S_DONE);
  assign o_pass           = o_done && (r_err == '0);
  assign o_err_count      = r_err;
  assign o_first_err_addr = r_ferr_addr;
  assign o_first_err_data = r_ferr_data;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: 16x8 memory model with optional stuck bit / all-zero read,
// expected write stream queued at start and popped as the DUT issues writes.
module tb_sram_bist;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_mode;
  logic       o_busy, o_done, o_pass;
  logic [1:0] o_err_count;
  logic [3:0] o_first_err_addr;
  logic [7:0] o_first_err_data;

  logic       fault_en;
  logic       zero_mem;
  logic [7:0] mem [16];

  logic [11:0] q[$];
  int vectors;
  int miscompares;

  sram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  sram_bist #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(15),
    .ACCESS_CYCLES(2), .ERR_WIDTH(2), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .i_clk(clk), .i_n_reset(rst_n), .i_start(i_start), .i_mode(i_mode),
    .m_if(bus),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_first_err_addr(o_first_err_addr), .o_first_err_data(o_first_err_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: address 9 can lose bit 3 on write; reads can be forced to zero
  always @(posedge clk) begin
    if (bus.o_m_write)
      mem[bus.o_m_addr] <= (fault_en && bus.o_m_addr == 4'd9) ? (bus.o_m_wdata & 8'hF7) : bus.o_m_wdata;
  end
  assign bus.i_m_rdata = zero_mem ? 8'h00 : mem[bus.o_m_addr];

  // Expected write stream for passes 1 and 3 (one entry per access)
  task automatic push_exp(input logic [1:0] mode);
    logic [15:0] lf;
    logic [7:0]  d;
    logic [3:0]  a;
    for (int p = 0; p < 2; p++) begin
      lf = 16'hACE1;
      for (int k = 0; k < 16; k++) begin
        a = 4'(k);
        case (mode)
          2'd0: d = {4'h0, a};
          2'd1: d = lf[7:0];
          2'd2: d = 8'h01 << (k % 8);
          default: d = a[0] ? 8'hAA : 8'h55;
        endcase
        if (p == 1) d = ~d;
        q.push_back({a, d});
        if (lf[0]) lf = (lf >> 1) ^ 16'hB400;
        else       lf = lf >> 1;
      end
    end
  endtask

  // Start a test and follow it cycle by cycle, popping the scoreboard on each new write access
  task automatic run(input logic [1:0] mode, input bit poke, input int abort_at,
                     output int cycles, output int wrc, output bit tmo,
                     output logic fbusy, output logic [3:0] faddr);
    logic       pw;
    logic [3:0] pa;
    logic [11:0] e;
    push_exp(mode);
    @(posedge clk); #1;
    i_mode  = mode;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    fbusy = o_busy;
    faddr = bus.o_m_addr;
    cycles = 0; wrc = 0; tmo = 1'b1; pw = 1'b0; pa = 4'd0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.o_m_write) begin
        wrc++;
        if (!pw || bus.o_m_addr != pa) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL write_sb: unexpected write addr=%0h data=%02h", bus.o_m_addr, bus.o_m_wdata);
          end else begin
            e = q.pop_front();
            if ({bus.o_m_addr, bus.o_m_wdata} !== e) begin
              miscompares++;
              $display("FAIL write_sb: got addr=%0h data=%02h want addr=%0h data=%02h",
                       bus.o_m_addr, bus.o_m_wdata, e[11:8], e[7:0]);
            end
          end
        end
      end
      pw = bus.o_m_write;
      pa = bus.o_m_addr;
      if (o_done || k == abort_at) begin
        tmo = 1'b0;
        break;
      end
      i_start = poke && (k == 20);
      @(posedge clk); #1;
      cycles++;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; fault_en = 1'b0; zero_mem = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_busy, o_done, o_pass, o_err_count, o_first_err_addr, o_first_err_data,
         bus.o_m_write, bus.o_m_addr, bus.o_m_wdata} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d addr=%0h wdata=%02h, all required 0",
               o_busy, o_done, o_pass, o_err_count, bus.o_m_addr, bus.o_m_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_busy, o_done, o_pass, bus.o_m_write, bus.o_m_addr} !== 8'd0) begin
      miscompares++;
      $display("FAIL idle_outputs: busy=%b done=%b write=%b addr=%0h, all required 0",
               o_busy, o_done, bus.o_m_write, bus.o_m_addr);
    end
  endtask

  task automatic test_addr_pattern();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    run(2'd0, 1'b0, -1, cyc, wrc, tmo, fb, fa);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL addr_timeout: o_done never rose"); end
    vectors++;
    if (fb !== 1'b1 || fa !== 4'd0) begin
      miscompares++; $display("FAIL start_latency: busy=%b addr=%0h want busy=1 addr=0", fb, fa);
    end
    vectors++;
    if (cyc !== 128) begin miscompares++; $display("FAIL addr_busy_time: got %0d want 128", cyc); end
    vectors++;
    if (wrc !== 64) begin miscompares++; $display("FAIL addr_write_cycles: got %0d want 64", wrc); end
    vectors++;
    if ({o_pass, o_err_count, o_busy} !== 4'b1000) begin
      miscompares++; $display("FAIL addr_result: pass=%b err=%0d busy=%b want 1/0/0", o_pass, o_err_count, o_busy);
    end
    vectors++;
    if (q.size() !== 0) begin miscompares++; $display("FAIL addr_sb_drain: %0d writes missing", q.size()); end
    vectors++;
    if ({bus.o_m_write, bus.o_m_addr} !== 5'd0) begin
      miscompares++; $display("FAIL done_bus: write=%b addr=%0h want 0/0", bus.o_m_write, bus.o_m_addr);
    end
  endtask

  task automatic test_stuck_bit();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    fault_en = 1'b1;
    run(2'd0, 1'b0, -1, cyc, wrc, tmo, fb, fa);
    fault_en = 1'b0;
    vectors++;
    if (tmo || o_err_count !== 2'd1 || o_pass !== 1'b0) begin
      miscompares++; $display("FAIL stuck_count: tmo=%b err=%0d pass=%b want 0/1/0", tmo, o_err_count, o_pass);
    end
    vectors++;
    if (o_first_err_addr !== 4'd9 || o_first_err_data !== 8'h01) begin
      miscompares++; $display("FAIL stuck_first: addr=%0h data=%02h want 9/01", o_first_err_addr, o_first_err_data);
    end
    vectors++;
    if (q.size() !== 0) begin miscompares++; $display("FAIL stuck_sb_drain: %0d writes missing", q.size()); end
  endtask

  task automatic test_checkerboard();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    run(2'd3, 1'b0, -1, cyc, wrc, tmo, fb, fa);
    vectors++;
    if (tmo || o_pass !== 1'b1 || o_err_count !== 2'd0 || q.size() !== 0) begin
      miscompares++; $display("FAIL checker_result: tmo=%b pass=%b err=%0d left=%0d want 0/1/0/0",
                              tmo, o_pass, o_err_count, q.size());
    end
  endtask

  task automatic test_saturate();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    zero_mem = 1'b1;
    run(2'd2, 1'b0, -1, cyc, wrc, tmo, fb, fa);
    zero_mem = 1'b0;
    vectors++;
    if (tmo || o_err_count !== 2'd3 || o_pass !== 1'b0) begin
      miscompares++; $display("FAIL sat_count: tmo=%b err=%0d pass=%b want 0/3/0", tmo, o_err_count, o_pass);
    end
    vectors++;
    if (o_first_err_addr !== 4'd0 || o_first_err_data !== 8'h00) begin
      miscompares++; $display("FAIL sat_first: addr=%0h data=%02h want 0/00", o_first_err_addr, o_first_err_data);
    end
    vectors++;
    if (q.size() !== 0) begin miscompares++; $display("FAIL sat_sb_drain: %0d writes missing", q.size()); end
  endtask

  task automatic test_lfsr();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    run(2'd1, 1'b0, -1, cyc, wrc, tmo, fb, fa);
    vectors++;
    if (tmo || o_pass !== 1'b1 || cyc !== 128 || q.size() !== 0) begin
      miscompares++; $display("FAIL lfsr_result: tmo=%b pass=%b cycles=%0d left=%0d want 0/1/128/0",
                              tmo, o_pass, cyc, q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, wrc; bit tmo; logic fb; logic [3:0] fa;
    run(2'd0, 1'b0, 40, cyc, wrc, tmo, fb, fa);
    vectors++;
    if (o_busy !== 1'b1 || bus.o_m_write !== 1'b0) begin
      miscompares++; $display("FAIL midrun_in_rd: busy=%b write=%b want 1/0", o_busy, bus.o_m_write);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({o_busy, o_done, o_pass, o_err_count, o_first_err_addr, o_first_err_data,
         bus.o_m_write, bus.o_m_addr, bus.o_m_wdata} !== 30'd0) begin
      miscompares++; $display("FAIL midrun_reset_outputs: busy=%b done=%b write=%b addr=%0h, all required 0",
                              o_busy, o_done, bus.o_m_write, bus.o_m_addr);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_busy, o_done, o_pass, o_err_count, bus.o_m_write, bus.o_m_addr} !== 10'd0) begin
      miscompares++; $display("FAIL after_reset_outputs: busy=%b done=%b err=%0d, all required 0",
                              o_busy, o_done, o_err_count);
    end
    run(2'd0, 1'b1, -1, cyc, wrc, tmo, fb, fa);
    vectors++;
    if (tmo || cyc !== 128 || o_pass !== 1'b1 || q.size() !== 0) begin
      miscompares++; $display("FAIL restart_result: tmo=%b cycles=%0d pass=%b left=%0d want 0/128/1/0",
                              tmo, cyc, o_pass, q.size());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_addr_pattern();
    test_stuck_bit();
    test_checkerboard();
    test_saturate();
    test_lfsr();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
# sram_bist

Parametrised built-in self-test sequencer for the external asynchronous SRAM. Sits between the top-level controller and the `sram_1Mx8` interface block. On command it runs a four-pass write/verify sweep over a configurable address range with a selectable data pattern, then reports pass/fail, a saturating error count and the first failing address and data.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: SRAM address width.
- `DATA_WIDTH`, 8: SRAM data width, 2..16.
- `LAST_ADDR`, 2^ADDR_WIDTH-1: highest address tested; the range is 0..LAST_ADDR inclusive.
- `ACCESS_CYCLES`, 2: clocks per SRAM access, ≥1.
- `ERR_WIDTH`, 16: error counter width.
- `LFSR_SEED`, 16'hACE1: LFSR seed, must be nonzero.

Ports:
- `i_clk`  in  1  system clock.
- `i_n_reset`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  start request, sampled each clock.
- `i_mode`  in  2  pattern select, latched at start.
- `o_m_write`  out  1  write strobe to the SRAM interface.
- `o_m_addr`  out  ADDR_WIDTH  access address.
- `o_m_wdata`  out  DATA_WIDTH  write data.
- `i_m_rdata`  in  DATA_WIDTH  read data from the SRAM interface.
- `o_busy`  out  1  test in progress.
- `o_done`  out  1  test finished (level).
- `o_pass`  out  1  valid while `o_done`; 1 means zero errors.
- `o_err_count`  out  ERR_WIDTH  saturating mismatch count.
- `o_first_err_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `o_first_err_data`  out  DATA_WIDTH  data read at the first mismatch.

## Operation
- FSM states: IDLE, WR, RD, WR_INV, RD_INV, DONE.
- From IDLE or DONE, `i_start`=1 does the following and enters WR:
  - latches `i_mode`;
  - clears the counter, the first-error registers and `o_done`;
  - sets address=0 and reseeds the LFSR.
- `i_start` is ignored while in WR, RD, WR_INV or RD_INV.
- Each pass sweeps address 0..LAST_ADDR with one access per address. After LAST_ADDR the FSM advances WR→RD→WR_INV→RD_INV→DONE.
- Between passes the address wraps to 0 and the LFSR is reseeded, so every pass regenerates the identical sequence.
- Expected pattern E(addr), by mode:
  - 0: address-as-data, addr[DATA_WIDTH-1:0].
  - 1: LFSR. 16-bit Galois, mask 16'hB400, shift right. Data = low DATA_WIDTH bits. The LFSR advances once per completed access.
  - 2: walking one, 1 << (addr mod DATA_WIDTH).
  - 3: checkerboard, bit i = (i even) XOR addr[0]. For DATA_WIDTH=8: 8'h55 at even addresses, 8'hAA at odd.
- Data written or expected per pass:
  - WR writes E and RD expects E.
  - WR_INV writes ~E and RD_INV expects ~E.
- On mismatch:
  - `o_err_count` increments, saturating at all-ones.
  - If this is the first error, the address and `i_m_rdata` are captured.
- DONE holds all results until the next start. `o_pass` = (`o_err_count`==0).
- Asynchronous reset at any time:
  - FSM returns to IDLE and all outputs go to 0;
  - the partial test is discarded and no result is reported.

## Timing
- Reset values: every output is 0.
- An `i_start` sampled at edge N gives `o_busy`=1, state WR and `o_m_addr`=0 from N+1.
- Each access holds `o_m_addr` and `o_m_wdata` stable for ACCESS_CYCLES clocks.
- `o_m_write`:
  - in write passes it is high for all ACCESS_CYCLES clocks of each access;
  - it is 0 in read passes, IDLE and DONE.
- In read passes `i_m_rdata` is compared at the clock edge ending the last cycle of each access. The counter and first-error registers update on that edge.
- Total busy time is 4·(LAST_ADDR+1)·ACCESS_CYCLES clocks. `o_busy` falls and `o_done`/`o_pass` rise on the same edge.
- `o_m_addr` returns to 0 in IDLE/DONE.
- Start asserted in the same cycle as entry to DONE is ignored; it must be sampled in DONE.

## Test plan
- Ideal memory model, ADDR_WIDTH=4, LAST_ADDR=15, DATA_WIDTH=8, ACCESS_CYCLES=2, mode 0, start pulse → `o_done`=1 exactly 128 clocks after start, `o_pass`=1, `o_err_count`=0; pass 1 writes 0x00..0x0F and pass 3 writes 0xFF..0xF0.
- Same setup, memory forces bit 3 of address 9 to 0 → `o_err_count`=1, `o_first_err_addr`=9, `o_first_err_data`=0x01, `o_pass`=0.
- Mode 3, ideal memory → write data at addresses 0, 1, 2 is 0x55, 0xAA, 0x55 in pass 1 and 0xAA, 0x55, 0xAA in pass 3; `o_pass`=1.
- ERR_WIDTH=2, memory always returns 0x00, mode 2 → `o_err_count` saturates at 3, `o_first_err_addr`=0, `o_first_err_data`=0x00.
- Mode 1 → the pass-3 write data equals the bitwise complement of the pass-1 sequence, element by element, and the test passes.
- `i_n_reset` pulsed low mid-RD, then restart → all outputs 0 during and after reset; the new test completes with `o_pass`=1. An `i_start` during busy changes nothing; the completion time is unchanged.
